// File: rtl/instruction_fetch.sv
// instruction_fetch: fetches one instruction per PC via a ready/valid handshake and publishes the PC update
module instruction_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSTRUCTION_LENGTH = 32,
  parameter int OS_START = 2048,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                          slow_clock,
  input  logic                          reset,
  input  logic [ADDR_WIDTH-1:0]         current_PC,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          mem_ready,
  input  logic [INSTRUCTION_LENGTH-1:0] mem_data,
  output logic                          mem_read,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [INSTRUCTION_LENGTH-1:0] instruction,
  output logic                          instruction_valid,
  input  logic                          instruction_accept,
  input  logic                          branch_taken,
  input  logic [ADDR_WIDTH-1:0]         branch_target,
  output logic [ADDR_WIDTH-1:0]         new_PC,
  output logic                          pc_update,
  output logic                          fetch_fault
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, UPDATE} state_t;
  state_t state, state_next;
  logic [CW-1:0] count;
  logic timeout;
  assign timeout = count == CW'(TIMEOUT_CYCLES - 1);
  // state register; reset drops mem_read at once because it decodes from state
  always_ff @(posedge slow_clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  // next state: flush wins over ready/timeout/accept, ready wins over timeout, UPDATE ignores flush
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = (flush || stall) ? IDLE : FETCH;
      FETCH:   state_next = flush ? IDLE : mem_ready ? HOLD : timeout ? UPDATE : FETCH;
      HOLD:    state_next = flush ? IDLE : instruction_accept ? UPDATE : HOLD;
      default: state_next = IDLE;
    endcase
  end
  // state-decoded outputs
  always_comb begin
    mem_read = state == FETCH;
    instruction_valid = state == HOLD;
    pc_update = state == UPDATE;
  end
  // datapath: fetch address, latched word, next PC, timeout counter and fault pulse
  always_ff @(posedge slow_clock or posedge reset)
    if (reset) begin
      mem_addr <= '0;
      instruction <= '0;
      new_PC <= '0;
      count <= '0;
      fetch_fault <= 1'b0;
    end else begin
      fetch_fault <= state == FETCH && !flush && !mem_ready && timeout;
      if (state == IDLE && state_next == FETCH) begin
        mem_addr <= current_PC;
        count <= '0;
      end
      if (flush && state != UPDATE) count <= '0;
      else if (state == FETCH) begin
        if (mem_ready) instruction <= mem_data;
        else if (timeout) new_PC <= ADDR_WIDTH'(OS_START);
        else count <= count + 1'b1;
      end else if (state == HOLD && instruction_accept)
        new_PC <= branch_taken ? branch_target : mem_addr + 1'b1;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that sits directly upstream of the register bank. It reads the current PC that the bank publishes, fetches one instruction word through a ready/valid memory handshake, and holds that word for decode. Once the instruction is accepted, it produces the `new_PC` value and a one-cycle write-enable pulse so the bank commits the PC update. A fetch that times out redirects execution to the OS entry point.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: PC and memory address width; PC is a word address.
- `INSTRUCTION_LENGTH`, 32: fetched word width.
- `OS_START`, 2048: PC loaded on fetch fault.
- `TIMEOUT_CYCLES`, 15: number of FETCH cycles without `mem_ready` before fault; must be ≥1.

Ports:
- `slow_clock` in 1: single clock. The block runs in the same domain as the bank's write port.
- `reset` in 1: asynchronous, active-high.
- `current_PC` in ADDR_WIDTH: PC as published by the register bank.
- `stall` in 1: when high, IDLE does not start a fetch.
- `flush` in 1: aborts any fetch or held instruction.
- `mem_ready` in 1: memory has valid data on `mem_data` this cycle.
- `mem_data` in INSTRUCTION_LENGTH: instruction word from memory.
- `mem_read` out 1: read request; held high for the whole FETCH state.
- `mem_addr` out ADDR_WIDTH: address of the fetch in progress.
- `instruction` out INSTRUCTION_LENGTH: latched instruction.
- `instruction_valid` out 1: `instruction` is held for decode.
- `instruction_accept` in 1: decode consumes `instruction`.
- `branch_taken` in 1: sampled together with accept; selects `branch_target`.
- `branch_target` in ADDR_WIDTH: redirect address.
- `new_PC` out ADDR_WIDTH: value for the bank's `new_PC` input.
- `pc_update` out 1: one-cycle pulse driving the bank's `enable`.
- `fetch_fault` out 1: one-cycle pulse on timeout.

## Operation
States: IDLE, FETCH, HOLD, UPDATE.

- **Reset** (async): state goes to IDLE. All outputs go to 0, including `new_PC`, `mem_addr`, `instruction`, and the timeout counter.
- **IDLE**
  - If `stall` is low: `mem_addr` <= `current_PC`, counter <= 0, go to FETCH.
  - If `stall` is high: remain in IDLE.
- **FETCH**
  - `mem_read` = 1.
  - If `mem_ready` is high: `instruction` <= `mem_data`, `instruction_valid` <= 1, go to HOLD.
  - Else, if counter == TIMEOUT_CYCLES-1: `new_PC` <= OS_START, `pc_update` <= 1, `fetch_fault` <= 1, go to UPDATE.
  - Otherwise counter increments.
- **HOLD**
  - `instruction` is stable and `instruction_valid` = 1.
  - On `instruction_accept`:
    - `new_PC` <= `branch_taken` ? `branch_target` : `mem_addr`+1. The +1 is modulo 2^ADDR_WIDTH, so all-ones wraps to 0.
    - `instruction_valid` <= 0, `pc_update` <= 1, go to UPDATE.
- **UPDATE**
  - Lasts one cycle. `pc_update` and `fetch_fault` are cleared on exit.
  - Go to IDLE. The bank writes at the end of this cycle, so IDLE samples the updated `current_PC`.
- **Flush** (any state except UPDATE)
  - Next state is IDLE. `instruction_valid`, `mem_read` and the counter are cleared.
  - No `pc_update` is generated and any `mem_data` response that cycle is discarded.
  - In UPDATE, flush is ignored and the PC write completes.
- **Priority**: flush beats `mem_ready`, timeout and accept. `mem_ready` beats timeout in the same cycle.
- `stall` affects only IDLE. A fetch in progress and a held instruction are unaffected.

## Timing
- Registered outputs; every state transition happens on a `slow_clock` rising edge.
- Minimum round trip, with `mem_ready` and `instruction_accept` high immediately:
  - cycle 0: IDLE.
  - cycle 1: FETCH, `mem_read` = 1.
  - cycle 2: HOLD, `instruction_valid` = 1.
  - cycle 3: UPDATE, `pc_update` = 1.
  - cycle 4: IDLE sees the new PC.
  - Total: 4 cycles per instruction.
- Fault path: exactly TIMEOUT_CYCLES cycles in FETCH, then one UPDATE cycle with `pc_update` = `fetch_fault` = 1 and `new_PC` = OS_START.
- `mem_addr` is constant from FETCH entry until the next IDLE-to-FETCH transition.
- Reset asserted mid-fetch drops `mem_read` immediately (asynchronously).

## Test plan
- **Sequential fetch**: reset, `current_PC`=0x10, `mem_ready` high in the first FETCH cycle with `mem_data`=0xE3A01005, accept in HOLD → `instruction`=0xE3A01005, UPDATE has `new_PC`=0x11 and `pc_update` high for exactly 1 cycle, 4-cycle round trip.
- **Branch**: accept with `branch_taken`=1, `branch_target`=0x200 → `new_PC`=0x200. Separately, PC=0xFFFFFFFF without branch → `new_PC`=0.
- **Timeout**: TIMEOUT_CYCLES=15, `mem_ready` held low → `mem_read` high for 15 cycles, then `new_PC`=2048, `fetch_fault` and `pc_update` pulse once, state returns to IDLE.
- **Ready on final timeout cycle**: `mem_ready` arrives exactly on counter=14 → instruction latched, no fault.
- **Flush**: flush during FETCH and during HOLD → IDLE next cycle, `instruction_valid`=0, no `pc_update`. Flush during UPDATE → `pc_update` still seen.
- **Stall/reset**: `stall` held high keeps IDLE with `mem_read`=0. Async reset asserted mid-FETCH → all outputs 0 before the next edge.
